fft_bin_serializer: RTL and testbench

- Unloads one 16-point FFT frame from the flattened parallel bus produced by the final butterfly round.
- Streams the frame out one complex bin per cycle under a valid/ready handshake, so it can feed narrow downstream logic such as a magnitude unit, FIFO or UART packer.
- Undoes the bit-reversed output ordering of the decimation-in-frequency pipeline.
- Holds one frame and accepts the next frame on the same cycle the last bin leaves, giving bubble-free back-to-back frames.

---
 rtl/fft_bin_serializer.sv | 156 +++++++++++++++
 tb/tb_fft_bin_serializer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bin_serializer.sv
// fft_bin_serializer
//
// Unloads one 16-point FFT frame from the parallel output bus of the final
// butterfly round and streams it out one complex bin per cycle under a
// valid/ready handshake. The frame is held in a 16-entry buffer. The next
// frame can be captured on the same edge that the last bin leaves, so
// back-to-back frames stream with no bubbles.
//
// Build option:
//   FFT_BITREV_EN  defined   -> position k emits element bitrev4(k), which
//                               gives natural frequency order 0..15.
//                  undefined -> position k emits element k, which is the raw
//                               array order. out_index then reports the array
//                               index, i.e. the bit-reversed bin number.
//
// Parameters:
//   DATA_WIDTH  width of each signed real/imag sample
//   OUT_SHIFT   arithmetic right shift applied to every emitted sample
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   x_in_flat_real  16 real parts; element i at [DATA_WIDTH*(16-i)-1 -: DATA_WIDTH]
//   x_in_flat_imag  16 imag parts, same layout
//   in_valid        frame on the x_in buses is valid
//   in_ready        frame can be captured this cycle (combinational)
//   out_real        signed real part of the current bin
//   out_imag        signed imag part of the current bin
//   out_index       stream position of the current bin
//   out_last        current bin is the 16th of the frame
//   out_valid       out_* carry a valid bin
//   out_ready       downstream accepts the bin this cycle

module fft_bin_serializer #(
  parameter int DATA_WIDTH = 20,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH*16-1:0]     x_in_flat_real,
  input  logic [DATA_WIDTH*16-1:0]     x_in_flat_imag,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_real,
  output logic signed [DATA_WIDTH-1:0] out_imag,
  output logic [3:0]                   out_index,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state, state_next;
  logic [3:0] k, k_next;

  logic signed [DATA_WIDTH-1:0] bus_real  [16];
  logic signed [DATA_WIDTH-1:0] bus_imag  [16];
  logic signed [DATA_WIDTH-1:0] hold_real [16];
  logic signed [DATA_WIDTH-1:0] hold_imag [16];

  logic signed [DATA_WIDTH-1:0] real_next, imag_next;
  logic last_next;
  logic xfer, last_pos, capture;

  // Maps a stream position to the buffer element that it emits.
  function automatic logic [3:0] elem_sel(input logic [3:0] pos);
`ifdef FFT_BITREV_EN
    return {pos[0], pos[1], pos[2], pos[3]};
`else
    return pos;
`endif
  endfunction

  // Split the flat buses into element arrays. Element 0 sits in the MSBs.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bus_real[i] = x_in_flat_real[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
      bus_imag[i] = x_in_flat_imag[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
    end
  end

  assign xfer     = (state == STREAM) && out_ready;
  assign last_pos = (k == 4'd15);

  // A new frame is accepted when idle, or when the final bin is leaving.
  // This allows the gapless hand-over from one frame to the next.
  assign in_ready = (state == IDLE) || (xfer && last_pos);
  assign capture  = in_valid && in_ready;

  assign out_valid = (state == STREAM);
  assign out_index = k;

  // Next-state and next-output logic.
  // On a capture, bin 0 is taken straight from the incoming bus because the
  // holding buffer only receives the frame on that same edge.
  // A stalled transfer leaves every output register unchanged.
  always_comb begin
    state_next = state;
    k_next     = k;
    real_next  = out_real;
    imag_next  = out_imag;
    last_next  = out_last;
    if (capture) begin
      state_next = STREAM;
      k_next     = 4'd0;
      real_next  = bus_real[elem_sel(4'd0)] >>> OUT_SHIFT;
      imag_next  = bus_imag[elem_sel(4'd0)] >>> OUT_SHIFT;
      last_next  = 1'b0;
    end else if (xfer) begin
      if (last_pos) begin
        state_next = IDLE;
        k_next     = 4'd0;
        last_next  = 1'b0;
      end else begin
        k_next     = k + 4'd1;
        real_next  = hold_real[elem_sel(k + 4'd1)] >>> OUT_SHIFT;
        imag_next  = hold_imag[elem_sel(k + 4'd1)] >>> OUT_SHIFT;
        last_next  = (k == 4'd14);
      end
    end
  end

  // State, position counter and output registers.
  // All of them clear asynchronously so that a partial frame is dropped at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= 4'd0;
      out_real <= '0;
      out_imag <= '0;
      out_last <= 1'b0;
    end else begin
      state    <= state_next;
      k        <= k_next;
      out_real <= real_next;
      out_imag <= imag_next;
      out_last <= last_next;
    end
  end

  // Holding buffer. Its contents are never observed until a capture has
  // written it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < 16; i++) begin
        hold_real[i] <= bus_real[i];
        hold_imag[i] <= bus_imag[i];
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// tb_fft_bin_serializer
//
// Self-checking bench for fft_bin_serializer. Two instances share the same
// stimulus: one with OUT_SHIFT=0 and one with OUT_SHIFT=4. A queue-based
// frame model predicts every emitted bin, in_ready and out_valid. A handful
// of literal expectations pin the model's ordering, latency and shift
// arithmetic. The same FFT_BITREV_EN macro selects the expected order.

module tb_fft_bin_serializer;

  localparam int DW = 20;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW*16-1:0] x_in_flat_real = '0;
  logic [DW*16-1:0] x_in_flat_imag = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic in_ready, out_last, out_valid;
  logic signed [DW-1:0] out_real, out_imag;
  logic [3:0] out_index;

  logic sh_in_ready, sh_out_last, sh_out_valid;
  logic signed [DW-1:0] sh_out_real, sh_out_imag;
  logic [3:0] sh_out_index;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  typedef struct {
    int idx;
    int re;
    int im;
    int last;
  } bin_t;

  typedef struct {
    int idx;
    int re;
    int im;
    int cyc;
  } rec_t;

  bin_t model_q[$];
  rec_t log_q[$];

`ifdef FFT_BITREV_EN
  int exp_order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
  int exp_order [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

  fft_bin_serializer #(.DATA_WIDTH(DW), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_in_flat_real(x_in_flat_real), .x_in_flat_imag(x_in_flat_imag),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  fft_bin_serializer #(.DATA_WIDTH(DW), .OUT_SHIFT(SH)) dut_sh (
    .clk(clk), .rst_n(rst_n),
    .x_in_flat_real(x_in_flat_real), .x_in_flat_imag(x_in_flat_imag),
    .in_valid(in_valid), .in_ready(sh_in_ready),
    .out_real(sh_out_real), .out_imag(sh_out_imag), .out_index(sh_out_index),
    .out_last(sh_out_last), .out_valid(sh_out_valid), .out_ready(out_ready)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int got, input int expected);
    tests_run++;
    if (got != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expected, cycle);
    end
  endtask

  // Floor division by 2**sh. This is the meaning of an arithmetic right shift.
  function automatic int floor_shift(input int v, input int sh);
    int d;
    int q;
    d = 1 << sh;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic int model_elem(input int pos);
`ifdef FFT_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) if ((pos & (1 << b)) != 0) r += 8 >> b;
    return r;
`else
    return pos;
`endif
  endfunction

  function automatic int bus_elem(input logic [DW*16-1:0] bus, input int i);
    logic signed [DW-1:0] v;
    v = bus[DW*(16-i)-1 -: DW];
    return int'(v);
  endfunction

  // Frame model and per-cycle compare.
  // Check at the falling edge, then advance the model at the rising edge
  // using the inputs that were sampled at the falling edge.
  always begin : compare
    logic s_in_valid, s_out_ready, exp_ready, xfer, cap;
    logic [DW*16-1:0] s_re, s_im;
    bin_t b;
    rec_t r;
    @(negedge clk);
    s_in_valid  = in_valid;
    s_out_ready = out_ready;
    s_re = x_in_flat_real;
    s_im = x_in_flat_imag;
    if (!rst_n) begin
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_index", int'(out_index), 0);
      checkOutput("reset out_real", int'(out_real), 0);
      checkOutput("reset in_ready", int'(in_ready), 1);
      checkOutput("reset sh out_valid", int'(sh_out_valid), 0);
    end else begin
      exp_ready = (model_q.size() == 0) || (model_q.size() == 1 && out_ready);
      checkOutput("in_ready", int'(in_ready), int'(exp_ready));
      checkOutput("sh in_ready", int'(sh_in_ready), int'(exp_ready));
      checkOutput("out_valid", int'(out_valid), int'(model_q.size() != 0));
      checkOutput("sh out_valid", int'(sh_out_valid), int'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        b = model_q[0];
        checkOutput("out_index", int'(out_index), b.idx);
        checkOutput("out_real", int'(out_real), b.re);
        checkOutput("out_imag", int'(out_imag), b.im);
        checkOutput("out_last", int'(out_last), b.last);
        checkOutput("sh out_index", int'(sh_out_index), b.idx);
        checkOutput("sh out_real", int'(sh_out_real), floor_shift(b.re, SH));
        checkOutput("sh out_imag", int'(sh_out_imag), floor_shift(b.im, SH));
        checkOutput("sh out_last", int'(sh_out_last), b.last);
        if (out_valid && out_ready) begin
          r.idx = int'(out_index);
          r.re  = int'(out_real);
          r.im  = int'(out_imag);
          r.cyc = cycle;
          log_q.push_back(r);
        end
      end
    end
    @(posedge clk);
    cycle++;
    if (!rst_n) begin
      model_q.delete();
    end else begin
      xfer = (model_q.size() != 0) && s_out_ready;
      cap  = s_in_valid && ((model_q.size() == 0) || (model_q.size() == 1 && s_out_ready));
      if (xfer) void'(model_q.pop_front());
      if (cap) begin
        for (int pos = 0; pos < 16; pos++) begin
          b.idx  = pos;
          b.re   = bus_elem(s_re, model_elem(pos));
          b.im   = bus_elem(s_im, model_elem(pos));
          b.last = (pos == 15) ? 1 : 0;
          model_q.push_back(b);
        end
      end
    end
  end

  // Drive a frame with element i = (re0 + step*i, im0 - step*i) and raise in_valid.
  task automatic applyStimulus(input int re0, input int im0, input int step);
    logic [DW-1:0] tr, ti;
    for (int i = 0; i < 16; i++) begin
      tr = DW'(re0 + step * i);
      ti = DW'(im0 - step * i);
      x_in_flat_real[DW*(16-i)-1 -: DW] = tr;
      x_in_flat_imag[DW*(16-i)-1 -: DW] = ti;
    end
    in_valid = 1'b1;
  endtask

  // Capture from IDLE. Returns in the cycle after the capture edge.
  task automatic captureFrame(input int re0, input int im0, input int step);
    applyStimulus(re0, im0, step);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitLog(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (log_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    checkOutput(name, log_q.size(), n);
  endtask

  initial begin : stimulus
    int ok;
    int c;
    int saved;
    logic seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("init out_valid", int'(out_valid), 0);
    checkOutput("init in_ready", int'(in_ready), 1);
    checkOutput("init out_index", int'(out_index), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Output order and first-bin latency with out_ready held high
    log_q.delete();
    out_ready = 1'b1;
    captureFrame(0, 0, 1);
    checkOutput("latency out_valid", int'(out_valid), 1);
    checkOutput("latency out_index", int'(out_index), 0);
    checkOutput("latency out_real", int'(out_real), 0);
    waitLog(16, 40, "order transfers");
    ok = 1;
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      if (log_q[i].re != exp_order[i] || log_q[i].im != -exp_order[i] || log_q[i].idx != i) ok = 0;
    end
    checkOutput("order literal table", ok, 1);
    checkOutput("order first to last span", log_q[15].cyc - log_q[0].cyc, 15);

    // Back-pressure with out_ready pattern 1,0,0 repeating
    repeat (2) @(posedge clk);
    #1;
    log_q.delete();
    out_ready = 1'b1;
    captureFrame(50, 7, 3);
    c = 0;
    while (log_q.size() < 16 && c < 100) begin
      out_ready = ((c % 3) == 0);
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("backpressure transfers", log_q.size(), 16);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("backpressure no extra bins", log_q.size(), 16);
    ok = 1;
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      if (log_q[i].idx != i || log_q[i].re != 50 + 3 * exp_order[i]) ok = 0;
    end
    checkOutput("backpressure sequence", ok, 1);
    checkOutput("backpressure idle in_ready", int'(in_ready), 1);

    // Back-to-back: B offered from cycle N+5 and held until it is taken
    log_q.delete();
    captureFrame(200, -200, 1);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(300, -300, 1);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 30) begin
      @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      #1;
      c++;
    end
    in_valid = 1'b0;
    checkOutput("b2b captured", int'(seen), 1);
    checkOutput("b2b A complete at capture", log_q.size(), 16);
    checkOutput("b2b B bin0 index", int'(out_index), 0);
    checkOutput("b2b B bin0 real", int'(out_real), 300);
    checkOutput("b2b B bin0 valid", int'(out_valid), 1);
    waitLog(32, 40, "b2b transfers");
    ok = 1;
    for (int i = 1; i < 32 && i < log_q.size(); i++) begin
      if (log_q[i].cyc != log_q[i-1].cyc + 1) ok = 0;
    end
    checkOutput("b2b contiguous", ok, 1);

    // Shift arithmetic on the OUT_SHIFT=4 instance
    repeat (2) @(posedge clk);
    #1;
    captureFrame(-524287, 370728, 1);
    checkOutput("shift out_real raw", int'(out_real), -524287);
    checkOutput("shift sh_out_real", int'(sh_out_real), -32768);
    checkOutput("shift sh_out_imag", int'(sh_out_imag), 23170);
    repeat (20) @(posedge clk);
    #1;

    // Asynchronous reset mid-frame at position 7
    log_q.delete();
    captureFrame(1, 2, 1);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 30) begin
      @(negedge clk);
      seen = out_valid && (out_index == 4'd7);
      c++;
    end
    checkOutput("reach position 7", int'(seen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", int'(out_valid), 0);
    checkOutput("async reset out_index", int'(out_index), 0);
    checkOutput("async reset out_real", int'(out_real), 0);
    checkOutput("async reset out_imag", int'(out_imag), 0);
    checkOutput("async reset out_last", int'(out_last), 0);
    checkOutput("async reset in_ready", int'(in_ready), 1);
    checkOutput("async reset sh out_real", int'(sh_out_real), 0);
    saved = log_q.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post reset no stale valid", int'(out_valid), 0);
    checkOutput("post reset no stale bins", log_q.size(), saved);
    checkOutput("post reset in_ready", int'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
